// File: rtl/bayer_mosaic_pkg.sv
// ---------------------------------------------------------------------------
// bayer_mosaic_pkg
// Shared video definitions used by both the re-mosaicing and the demosaicing
// paths, so both ends agree on CFA phase, RGB byte packing and frame state.
//   - CFA pattern constants (RGGB, GRBG, GBRG, BGGR = 0..3)
//   - RGB byte-lane offsets inside a 24-bit pixel {R, G, B}
//   - frame state encoding
//   - helpers: CFA phase flips for a pattern, per-site sample selection
// ---------------------------------------------------------------------------
package bayer_mosaic_pkg;

  localparam logic [1:0] CFA_RGGB = 2'd0;
  localparam logic [1:0] CFA_GRBG = 2'd1;
  localparam logic [1:0] CFA_GBRG = 2'd2;
  localparam logic [1:0] CFA_BGGR = 2'd3;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic {
    ST_WAIT_SOF = 1'b0,
    ST_ACTIVE   = 1'b1
  } frame_state_t;

  // Returns {row_flip, col_flip}: how the RGGB reference grid is shifted to
  // produce the requested pattern.
  function automatic logic [1:0] cfa_phase(input logic [1:0] pattern);
    logic [1:0] flips;
    flips = 2'b00;
    case (pattern)
      CFA_RGGB: flips = 2'b00;
      CFA_GRBG: flips = 2'b01;
      CFA_GBRG: flips = 2'b10;
      CFA_BGGR: flips = 2'b11;
      default:  flips = 2'b00;
    endcase
    return flips;
  endfunction

  // Picks the colour plane for one site of the RGGB reference grid:
  // (0,0) red, (1,1) blue, the two diagonal sites green.
  function automatic logic [7:0] cfa_sample(input logic [23:0] rgb,
                                            input logic        pr,
                                            input logic        pc);
    logic [7:0] sample;
    sample = rgb[G_LSB +: 8];
    case ({pr, pc})
      2'b00:   sample = rgb[R_LSB +: 8];
      2'b11:   sample = rgb[B_LSB +: 8];
      default: sample = rgb[G_LSB +: 8];
    endcase
    return sample;
  endfunction

endpackage

// File: rtl/bayer_pos_counter.sv
// ---------------------------------------------------------------------------
// bayer_pos_counter
// Tracks the raster position of each accepted beat and the frame state.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   beat_valid        input beat valid
//   beat_sof          start-of-frame marker of the beat (tuser)
//   beat_eol          end-of-line marker of the beat (tlast)
//   row_lsb, col_lsb  position parity of the current beat (after SOF resync)
//   frame_active      current beat is accepted and must be emitted
//   err_sof           current beat carries SOF away from (0,0)
//   err_eol           current beat ends a line at the wrong length
// All outputs describe the beat presented this cycle; the top registers them.
// ---------------------------------------------------------------------------
module bayer_pos_counter
  import bayer_mosaic_pkg::*;
#(
  parameter int Nrows = 349,
  parameter int Ncol  = 349
) (
  input  logic clk,
  input  logic rst,
  input  logic beat_valid,
  input  logic beat_sof,
  input  logic beat_eol,
  output logic row_lsb,
  output logic col_lsb,
  output logic frame_active,
  output logic err_sof,
  output logic err_eol
);

  localparam int ROW_W = (Nrows > 1) ? $clog2(Nrows) : 1;
  localparam int COL_W = (Ncol  > 1) ? $clog2(Ncol)  : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(Nrows - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(Ncol - 1);

  frame_state_t     state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  logic [ROW_W-1:0] eff_row;
  logic [COL_W-1:0] eff_col;
  logic             at_col_last;
  logic             line_end;

  // A SOF beat always counts as (0,0), whether it opens a frame or
  // resynchronises one in progress; the stored position is only used
  // otherwise. A line ends on tlast or on reaching the last column, and an
  // error is flagged whenever those two disagree.
  always_comb begin
    frame_active = beat_valid && ((state == ST_ACTIVE) || beat_sof);
    eff_row      = beat_sof ? '0 : row;
    eff_col      = beat_sof ? '0 : col;
    at_col_last  = (eff_col == COL_LAST);
    line_end     = beat_eol || at_col_last;
    row_lsb      = eff_row[0];
    col_lsb      = eff_col[0];
    err_sof      = frame_active && (state == ST_ACTIVE) && beat_sof &&
                   ((row != '0) || (col != '0));
    err_eol      = frame_active && (beat_eol != at_col_last);
  end

  // Position and frame state advance only on accepted beats; finishing the
  // last line drops back to waiting for the next SOF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_WAIT_SOF;
      row   <= '0;
      col   <= '0;
    end else if (frame_active) begin
      if (line_end) begin
        col <= '0;
        if (eff_row == ROW_LAST) begin
          row   <= '0;
          state <= ST_WAIT_SOF;
        end else begin
          row   <= eff_row + 1'b1;
          state <= ST_ACTIVE;
        end
      end else begin
        col   <= eff_col + 1'b1;
        row   <= eff_row;
        state <= ST_ACTIVE;
      end
    end
  end

endmodule

// File: rtl/bayer_mosaic.sv
// ---------------------------------------------------------------------------
// bayer_mosaic
// Converts a 24-bit RGB AXI-Stream frame into an 8-bit Bayer (CFA) stream,
// one sample per pixel, with one cycle of latency. No backpressure.
// Parameters: Nrows (lines/frame), Ncol (pixels/line), PATTERN (CFA phase,
//   0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR).
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   s_axis_tvalid/tuser/tlast/tdata  RGB input, tdata = {R, G, B}
//   m_axis_tvalid/tuser/tlast/tdata  Bayer output, tdata = selected sample
//   err_sof                          pulse: tuser seen away from (0,0)
//   err_eol                          pulse: line length mismatch
// ---------------------------------------------------------------------------
module bayer_mosaic
  import bayer_mosaic_pkg::*;
#(
  parameter int         Nrows   = 349,
  parameter int         Ncol    = 349,
  parameter logic [1:0] PATTERN = CFA_RGGB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic [23:0] s_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        err_sof,
  output logic        err_eol
);

  localparam logic [1:0] PHASE = cfa_phase(PATTERN);

  logic row_lsb;
  logic col_lsb;
  logic frame_active;
  logic beat_err_sof;
  logic beat_err_eol;

  bayer_pos_counter #(
    .Nrows (Nrows),
    .Ncol  (Ncol)
  ) u_pos (
    .clk          (clk),
    .rst          (rst),
    .beat_valid   (s_axis_tvalid),
    .beat_sof     (s_axis_tuser),
    .beat_eol     (s_axis_tlast),
    .row_lsb      (row_lsb),
    .col_lsb      (col_lsb),
    .frame_active (frame_active),
    .err_sof      (beat_err_sof),
    .err_eol      (beat_err_eol)
  );

  // Output stage: markers and error pulses follow the beat that caused them,
  // while the sample register only loads on emitted beats so tdata holds its
  // last value through gaps and dropped input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= 8'd0;
      err_sof       <= 1'b0;
      err_eol       <= 1'b0;
    end else begin
      m_axis_tvalid <= frame_active;
      m_axis_tuser  <= frame_active && s_axis_tuser;
      m_axis_tlast  <= frame_active && s_axis_tlast;
      err_sof       <= beat_err_sof;
      err_eol       <= beat_err_eol;
      if (frame_active) begin
        m_axis_tdata <= cfa_sample(s_axis_tdata,
                                   row_lsb ^ PHASE[1],
                                   col_lsb ^ PHASE[0]);
      end
    end
  end

endmodule

// File: tb/tb_bayer_mosaic.sv
// ---------------------------------------------------------------------------
// tb_bayer_mosaic
// Directed bench for bayer_mosaic on a 4x4 frame. Two instances share the
// input stream: one RGGB (PATTERN 0) and one BGGR (PATTERN 3). Every pixel
// is R=0x11 G=0x22 B=0x33, so each output sample identifies its colour.
// ---------------------------------------------------------------------------
module tb_bayer_mosaic;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tuser  = 1'b0;
  logic        s_tlast  = 1'b0;
  logic [23:0] s_tdata  = 24'h0;

  logic        m0_tvalid, m0_tuser, m0_tlast, m0_err_sof, m0_err_eol;
  logic [7:0]  m0_tdata;
  logic        m3_tvalid, m3_tuser, m3_tlast, m3_err_sof, m3_err_eol;
  logic [7:0]  m3_tdata;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] PIX = 24'h112233;

  // Expected samples indexed [row parity][col parity], worked out by hand.
  logic [7:0] tab0 [2][2] = '{'{8'h11, 8'h22}, '{8'h22, 8'h33}};
  logic [7:0] tab3 [2][2] = '{'{8'h33, 8'h22}, '{8'h22, 8'h11}};

  logic [7:0] held0 = 8'h00;
  logic [7:0] held3 = 8'h00;

  always #5 clk = ~clk;

  bayer_mosaic #(.Nrows(4), .Ncol(4), .PATTERN(2'd0)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m0_tvalid),
    .m_axis_tuser  (m0_tuser),
    .m_axis_tlast  (m0_tlast),
    .m_axis_tdata  (m0_tdata),
    .err_sof       (m0_err_sof),
    .err_eol       (m0_err_eol)
  );

  bayer_mosaic #(.Nrows(4), .Ncol(4), .PATTERN(2'd3)) dut3 (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m3_tvalid),
    .m_axis_tuser  (m3_tuser),
    .m_axis_tlast  (m3_tlast),
    .m_axis_tdata  (m3_tdata),
    .err_sof       (m3_err_sof),
    .err_eol       (m3_err_eol)
  );

  task automatic checkVal(input string name, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Drives one cycle of input and moves to 1 time unit after the edge that
  // captured it, where the registered outputs for that beat are visible.
  task automatic applyStimulus(input logic v, input logic u, input logic l);
    s_tvalid = v;
    s_tuser  = u;
    s_tlast  = l;
    s_tdata  = PIX;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic eu, input logic el,
                             input logic pr, input logic pc, input logic esf, input logic eel);
    if (ev) begin
      held0 = tab0[pr][pc];
      held3 = tab3[pr][pc];
    end
    checkVal({tag, ".valid0"}, {7'b0, m0_tvalid}, {7'b0, ev});
    checkVal({tag, ".valid3"}, {7'b0, m3_tvalid}, {7'b0, ev});
    if (ev) begin
      checkVal({tag, ".user0"}, {7'b0, m0_tuser}, {7'b0, eu});
      checkVal({tag, ".user3"}, {7'b0, m3_tuser}, {7'b0, eu});
      checkVal({tag, ".last0"}, {7'b0, m0_tlast}, {7'b0, el});
      checkVal({tag, ".last3"}, {7'b0, m3_tlast}, {7'b0, el});
    end
    checkVal({tag, ".data0"}, m0_tdata, held0);
    checkVal({tag, ".data3"}, m3_tdata, held3);
    checkVal({tag, ".esof0"}, {7'b0, m0_err_sof}, {7'b0, esf});
    checkVal({tag, ".esof3"}, {7'b0, m3_err_sof}, {7'b0, esf});
    checkVal({tag, ".eeol0"}, {7'b0, m0_err_eol}, {7'b0, eel});
    checkVal({tag, ".eeol3"}, {7'b0, m3_err_eol}, {7'b0, eel});
  endtask

  task automatic checkReset(input string tag);
    held0 = 8'h00;
    held3 = 8'h00;
    checkVal({tag, ".valid0"}, {7'b0, m0_tvalid}, 8'h00);
    checkVal({tag, ".user0"},  {7'b0, m0_tuser},  8'h00);
    checkVal({tag, ".last0"},  {7'b0, m0_tlast},  8'h00);
    checkVal({tag, ".data0"},  m0_tdata,          8'h00);
    checkVal({tag, ".esof0"},  {7'b0, m0_err_sof}, 8'h00);
    checkVal({tag, ".eeol0"},  {7'b0, m0_err_eol}, 8'h00);
    checkVal({tag, ".valid3"}, {7'b0, m3_tvalid}, 8'h00);
    checkVal({tag, ".data3"},  m3_tdata,          8'h00);
  endtask

  task automatic step(input string tag, input logic v, input logic u, input logic l,
                      input logic ev, input logic eu, input logic el,
                      input logic pr, input logic pc, input logic esf, input logic eel);
    applyStimulus(v, u, l);
    checkOutput(tag, ev, eu, el, pr, pc, esf, eel);
  endtask

  // One clean beat of a well-formed frame at (r, c).
  task automatic goodBeat(input string tag, input int r, input int c);
    logic first;
    logic last;
    first = (r == 0) && (c == 0);
    last  = (c == 3);
    step($sformatf("%s_r%0d_c%0d", tag, r, c), 1'b1, first, last,
         1'b1, first, last, r[0], c[0], 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state, held for two edges.
    #1;
    checkReset("reset0");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Beats before any tuser are dropped.
    for (int i = 0; i < 5; i++)
      step("pre_sof", 1'b1, 1'b0, (i == 3), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean frame, one idle cycle mid-frame (tdata must hold).
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        goodBeat("f1", r, c);
        if (r == 1 && c == 1)
          step("f1_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    // After the last line, non-tuser beats are dropped again.
    for (int i = 0; i < 3; i++)
      step("post_frame", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame with line-length errors.
    for (int c = 0; c < 4; c++) goodBeat("f2", 0, c);
    goodBeat("f2", 1, 0);
    goodBeat("f2", 1, 1);
    step("f2_early_tlast", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++)
      step($sformatf("f2_r2_c%0d", c), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c[0], 1'b0, 1'b0);
    step("f2_missing_tlast", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) goodBeat("f2", 3, c);
    step("f2_drop", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame with a stray tuser at (row 1, col 2): resync to (0,0).
    for (int c = 0; c < 4; c++) goodBeat("f3", 0, c);
    goodBeat("f3", 1, 0);
    goodBeat("f3", 1, 1);
    step("f3_stray_sof", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("f3_after_resync", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-line for one cycle clears everything at once.
    rst = 1'b0;
    #1;
    checkReset("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkReset("rst_release");
    for (int i = 0; i < 3; i++)
      step("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean frame with random tvalid gaps: same sample sequence as frame 1.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++)
          step("f4_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        goodBeat("f4", r, c);
      end
    end
    step("f4_drop", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
